// File: rtl/cg_ctrl_pkg.sv
// Shared definitions for the multi-channel clock-gating controller:
// channel FSM state encoding and the idle-threshold comparison.
package cg_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2,
    IDLE = 2'd3
  } cg_state_e;

  // True when one more idle cycle reaches the threshold; a zero threshold never fires.
  // Counters up to 32 bits are zero-extended by the caller.
  function automatic logic thr_hit(input logic [31:0] cnt, input logic [31:0] thr);
    logic [32:0] nxt;
    nxt = {1'b0, cnt} + 33'd1;
    return (thr != 32'd0) && (nxt >= {1'b0, thr});
  endfunction

endpackage

// File: rtl/clock_gate_cell.sv
// Single glitch-free clock gate: the enable only changes while clk_in is low,
// either through a low-transparent latch or a falling-edge register.
module clock_gate_cell #(
  parameter int LATCH_BASED = 1
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic gate_en,
  input  logic test_mode,
  output logic clk_out
);

  logic en_q;
  logic tm_q;

  if (LATCH_BASED != 0) begin : g_latch
    always_latch begin
      if (!rst_n) begin
        en_q <= 1'b0;
      end else if (!clk_in) begin
        en_q <= gate_en;
      end
    end

    // test_mode is not reset so scan clocks keep running while rst_n is held low
    always_latch begin
      if (!clk_in) begin
        tm_q <= test_mode;
      end
    end
  end else begin : g_reg
    always_ff @(negedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        en_q <= 1'b0;
      end else begin
        en_q <= gate_en;
      end
    end

    always_ff @(negedge clk_in) begin
      tm_q <= test_mode;
    end
  end

  assign clk_out = clk_in & (en_q | tm_q);

endmodule

// File: rtl/multi_channel_clock_gating.sv
// Per-channel gated clocks from one root clock: enable synchronisers, polarity
// handling, and an OFF/WAKE/RUN/IDLE FSM with an idle auto-gating counter.
module multi_channel_clock_gating
  import cg_ctrl_pkg::*;
#(
  parameter int NUM_CH            = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int IDLE_CNT_W        = 8,
  parameter int LATCH_BASED       = 1,
  parameter int ENABLE_ACTIVE_LOW = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [NUM_CH-1:0]     ch_activity,
  input  logic [IDLE_CNT_W-1:0] idle_threshold,
  input  logic                  test_mode,
  output logic [NUM_CH-1:0]     clk_out,
  output logic [NUM_CH-1:0]     ch_ready,
  output logic [NUM_CH-1:0]     ch_gated
);

  // Synchroniser flops reset to the inactive request level of the chosen polarity.
  localparam logic [NUM_CH-1:0] EN_INACTIVE = (ENABLE_ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : '0;

  logic [NUM_CH-1:0] en_sync;
  logic [NUM_CH-1:0] en_final;

  function automatic logic [IDLE_CNT_W-1:0] sat_inc(input logic [IDLE_CNT_W-1:0] v);
    return (v == {IDLE_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  if (SYNC_STAGES == 0) begin : g_nosync
    assign en_sync = ch_enable;
  end else begin : g_sync
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= EN_INACTIVE;
      end else begin
        sync_q[0] <= ch_enable;
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
    end

    assign en_sync = sync_q[SYNC_STAGES-1];
  end

  assign en_final = (ENABLE_ACTIVE_LOW != 0) ? ~en_sync : en_sync;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cg_state_e             state_q, state_d;
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ready_q;
    logic                  gated_q;

    // Priority: loss of enable, then activity, then idle timeout.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        OFF: begin
          if (en_final[i]) state_d = WAKE;
        end
        WAKE: begin
          cnt_d   = '0;
          state_d = en_final[i] ? RUN : OFF;
        end
        RUN: begin
          if (!en_final[i]) begin
            state_d = OFF;
          end else if (ch_activity[i]) begin
            cnt_d = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
            if (thr_hit(32'(cnt_q), 32'(idle_threshold))) state_d = IDLE;
          end
        end
        IDLE: begin
          if (!en_final[i]) begin
            state_d = OFF;
          end else if (ch_activity[i]) begin
            state_d = WAKE;
          end
        end
        default: state_d = OFF;
      endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= OFF;
        cnt_q   <= '0;
        ready_q <= 1'b0;
        gated_q <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ready_q <= (state_d == RUN);
        gated_q <= !((state_d == WAKE) || (state_d == RUN));
      end
    end

    clock_gate_cell #(
      .LATCH_BASED(LATCH_BASED)
    ) u_cg (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .gate_en  (!gated_q),
      .test_mode(test_mode),
      .clk_out  (clk_out[i])
    );

    assign ch_ready[i] = ready_q;
    assign ch_gated[i] = gated_q;
  end

endmodule
